fib_seq_ctrl: RTL and testbench

FIB_SEQ_CTRL -- requirements
Module: fib_seq_ctrl

---
 rtl/fib_seq_ctrl.sv | 86 ++++++++
 tb/tb_fib_seq_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fib_seq_ctrl.sv
// Sequencing controller for an external Fibonacci datapath: clears it, then streams
// num_terms terms over a valid/ready interface, flagging modulo-2^W wraparound.
module fib_seq_ctrl #(
  parameter int unsigned W     = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_terms,
  output logic             fib_clr,
  output logic             fib_en,
  input  logic [W-1:0]     fib_val,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  typedef enum logic [1:0] {S_IDLE, S_CLR, S_EMIT, S_FIN} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_remaining;
  logic [W-1:0]     r_prev;
  logic             r_overflow;
  logic             r_seen;
  logic             w_hs;
  logic             w_last;
  logic             w_accept;

  assign w_hs     = (r_state == S_EMIT) && out_ready;
  assign w_last   = (r_remaining == CNT_W'(1));
  assign w_accept = (r_state == S_IDLE) && start;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = (num_terms == '0) ? S_FIN : S_CLR;
      S_CLR:  w_next = S_EMIT;
      S_EMIT: if (w_hs && w_last) w_next = S_FIN;
      S_FIN:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // r_seen distinguishes the first beat of a run, which has no predecessor to compare.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_remaining <= '0;
      r_prev      <= '0;
      r_overflow  <= 1'b0;
      r_seen      <= 1'b0;
    end else if (w_accept) begin
      if (num_terms != '0) r_remaining <= num_terms;
      r_prev     <= '0;
      r_overflow <= 1'b0;
      r_seen     <= 1'b0;
    end else if (w_hs) begin
      if (r_seen && (fib_val < r_prev)) r_overflow <= 1'b1;
      r_prev <= fib_val;
      r_seen <= 1'b1;
      if (!w_last) r_remaining <= r_remaining - CNT_W'(1);
    end
  end

  always_comb begin
    fib_clr   = (r_state == S_CLR);
    fib_en    = w_hs && !w_last;
    out_valid = (r_state == S_EMIT);
    out_last  = (r_state == S_EMIT) && w_last;
    out_data  = fib_val;
    busy      = (r_state != S_IDLE);
    done      = (r_state == S_FIN);
    overflow  = r_overflow;
  end

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// Randomized bench for fib_seq_ctrl with an attached Fibonacci datapath and a
// timeline-level reference model of what each run must look like.
module tb_fib_seq_ctrl;
  localparam int unsigned W     = 8;
  localparam int unsigned CNT_W = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] num_terms;
  logic             fib_clr;
  logic             fib_en;
  logic [W-1:0]     fib_val;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic             out_last;
  logic             busy;
  logic             done;
  logic             overflow;

  fib_seq_ctrl #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .num_terms(num_terms),
    .fib_clr(fib_clr), .fib_en(fib_en), .fib_val(fib_val),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done), .overflow(overflow)
  );

  // Attached datapath: fib_val = current term, r_nxt = following term.
  logic [W-1:0] r_nxt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fib_val <= '0;
      r_nxt   <= 8'd1;
    end else if (fib_clr) begin
      fib_val <= '0;
      r_nxt   <= 8'd1;
    end else if (fib_en) begin
      fib_val <= r_nxt;
      r_nxt   <= fib_val + r_nxt;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  int fibtab [0:255];
  initial begin
    fibtab[0] = 0;
    fibtab[1] = 1;
    for (int k = 2; k < 256; k++) fibtab[k] = (fibtab[k-1] + fibtab[k-2]) % 256;
  end

  // Model of the run in progress, describing the current cycle.
  bit m_active = 0;
  int m_n = 0;
  int m_cyc = 0;
  int m_beats = 0;
  bit m_ovf = 0;

  logic [W-1:0] cap[$];
  int cnt_valid, cnt_clr, cnt_busy, cnt_done;

  always @(negedge clk) begin
    bit ev, eclr, edone, elast, een;
    if (!rst) begin
      chk("rst_busy", busy, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_clr", fib_clr, 0);
      chk("rst_en", fib_en, 0);
      chk("rst_last", out_last, 0);
      chk("rst_ovf", overflow, 0);
      m_active = 0;
      m_ovf    = 0;
    end else begin
      ev    = m_active && m_n != 0 && m_cyc >= 2 && m_beats < m_n;
      eclr  = m_active && m_n != 0 && m_cyc == 1;
      edone = m_active && ((m_n == 0 && m_cyc == 1) || (m_n != 0 && m_beats == m_n));
      elast = ev && (m_beats == m_n - 1);
      een   = ev && out_ready && !elast;
      chk("out_valid", out_valid, ev);
      chk("fib_clr", fib_clr, eclr);
      chk("fib_en", fib_en, een);
      chk("done", done, edone);
      chk("busy", busy, m_active);
      chk("out_last", out_last, elast);
      chk("overflow", overflow, m_ovf);
      if (ev) chk("out_data", out_data, fibtab[m_beats]);
      if (out_valid) cnt_valid++;
      if (fib_clr)   cnt_clr++;
      if (busy)      cnt_busy++;
      if (done)      cnt_done++;
      if (out_valid && out_ready) cap.push_back(out_data);
      if (!m_active) begin
        if (start) begin
          m_active = 1;
          m_n      = int'(num_terms);
          m_cyc    = 1;
          m_beats  = 0;
          m_ovf    = 0;
        end
      end else begin
        if (ev && out_ready) begin
          if (m_beats > 0 && fibtab[m_beats] < fibtab[m_beats-1]) m_ovf = 1;
          m_beats++;
        end
        if (edone) m_active = 0;
        m_cyc++;
      end
    end
  end

  function automatic logic pick_ready(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      1:       return (k % 3) == 0;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // Runs are launched at posedge+1 and followed until the model returns to idle.
  task automatic run(input int n, input int mode, input bit poke);
    int k;
    cap.delete();
    cnt_valid = 0; cnt_clr = 0; cnt_busy = 0; cnt_done = 0;
    @(posedge clk); #1;
    start = 1'b1; num_terms = CNT_W'(n); out_ready = pick_ready(mode, 0);
    @(posedge clk); #1;
    start = 1'b0; num_terms = CNT_W'($urandom);
    k = 0;
    while (m_active && k < 2000) begin
      out_ready = pick_ready(mode, k);
      if (poke && k == 2) begin
        start = 1'b1;
        num_terms = CNT_W'(n + 3);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;
    if (k >= 2000) chk("run_timeout", k, 0);
  endtask

  initial begin
    int k;
    rst = 1'b0; start = 1'b0; num_terms = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    run(5, 0, 0);
    chk("r5_len", cap.size(), 5);
    if (cap.size() == 5) begin
      chk("r5_b0", cap[0], 0); chk("r5_b1", cap[1], 1); chk("r5_b2", cap[2], 1);
      chk("r5_b3", cap[3], 2); chk("r5_b4", cap[4], 3);
    end
    chk("r5_ovf", overflow, 0);
    chk("r5_done_cnt", cnt_done, 1);

    run(4, 1, 0);
    chk("bp_len", cap.size(), 4);
    if (cap.size() == 4) begin
      chk("bp_b0", cap[0], 0); chk("bp_b1", cap[1], 1);
      chk("bp_b2", cap[2], 1); chk("bp_b3", cap[3], 2);
    end

    run(15, 0, 0);
    chk("r15_len", cap.size(), 15);
    if (cap.size() == 15) begin
      chk("r15_b13", cap[13], 233);
      chk("r15_b14", cap[14], 121);
    end
    chk("r15_ovf_held", overflow, 1);

    run(0, 0, 0);
    chk("z_valid_cnt", cnt_valid, 0);
    chk("z_clr_cnt", cnt_clr, 0);
    chk("z_busy_cnt", cnt_busy, 1);
    chk("z_done_cnt", cnt_done, 1);
    chk("z_ovf_cleared", overflow, 0);

    run(8, 0, 1);
    chk("poke_len", cap.size(), 8);

    run(255, 2, 0);
    chk("max_len", cap.size(), 255);

    // Asynchronous reset in the middle of the third beat.
    cap.delete(); cnt_done = 0;
    @(posedge clk); #1; start = 1'b1; num_terms = 8'd6; out_ready = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    k = 0;
    while (!(m_active && m_cyc >= 2 && m_beats == 2) && k < 50) begin
      @(posedge clk); #1; k++;
    end
    if (k >= 50) chk("abort_timeout", k, 0);
    rst = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_valid", out_valid, 0);
    chk("abort_last", out_last, 0);
    chk("abort_done", done, 0);
    chk("abort_clr", fib_clr, 0);
    chk("abort_en", fib_en, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_done", cnt_done, 0);
    chk("abort_idle", busy, 0);
    run(2, 0, 0);
    chk("post_len", cap.size(), 2);
    if (cap.size() == 2) begin
      chk("post_b0", cap[0], 0);
      chk("post_b1", cap[1], 1);
    end

    for (int r = 0; r < 12; r++) begin
      int n;
      int mode;
      n = $urandom_range(0, 24);
      mode = $urandom_range(0, 2);
      run(n, mode, n >= 4 && ($urandom_range(0, 1) == 1));
      chk("rand_len", cap.size(), n);
    end

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
